// File: rtl/riscv_end_monitor_if.sv
// Retirement-stage view of the core as seen by the end-of-simulation monitor.
// The core wrapper drives the master side; the monitor samples the slave side.
interface riscv_end_monitor_if #(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int REG_WIDTH  = 32
);
    logic                  wb_valid;
    logic [INST_WIDTH-1:0] wb_inst;
    logic [PC_WIDTH-1:0]   wb_pc;
    logic                  wb_known;
    logic [REG_WIDTH-1:0]  wb_a0;

    modport master (
        output wb_valid, wb_inst, wb_pc, wb_known, wb_a0
    );

    modport slave (
        input wb_valid, wb_inst, wb_pc, wb_known, wb_a0
    );
endinterface

// File: rtl/riscv_end_monitor.sv
// End-of-simulation monitor: counts cycles/retirements, detects halt or timeout.
// Optional a0 signature verdict when RISCV_END_MONITOR_SIGNATURE_EN is defined.
module riscv_end_monitor #(
    parameter int INST_WIDTH      = 32,
    parameter int PC_WIDTH        = 32,
    parameter int REG_WIDTH       = 32,
    parameter int CNT_WIDTH       = 32,
    parameter int DRAIN_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES  = 200,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    riscv_end_monitor_if.slave   wb,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           halt_cause,
    output logic [PC_WIDTH-1:0]  halt_pc,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt,
    output logic                 pass
);
    typedef enum logic [1:0] {
        S_IDLE, S_RUN, S_DRAIN, S_DONE
    } state_t;

    localparam logic [2:0] C_NONE    = 3'd0;
    localparam logic [2:0] C_ECALL   = 3'd1;
    localparam logic [2:0] C_EBREAK  = 3'd2;
    localparam logic [2:0] C_ILLEGAL = 3'd3;
    localparam logic [2:0] C_UNKNOWN = 3'd4;
    localparam logic [2:0] C_TIMEOUT = 3'd5;

    localparam logic [INST_WIDTH-1:0] ECALL_W  = INST_WIDTH'(32'h0000_0073);
    localparam logic [INST_WIDTH-1:0] EBREAK_W = INST_WIDTH'(32'h0010_0073);
    localparam logic [REG_WIDTH-1:0]  A0_PASS  = '0;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD =
        DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST =
        CNT_WIDTH'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t          state, state_nx;
    logic [DW-1:0]   drain_cnt;
    logic [2:0]      dec_cause;
    logic            op_legal;
    logic            halt_hit;
    logic            legal_ret;
    logic            timeout_hit;
    logic            pass_nx;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        op_legal = 1'b0;
        unique case (wb.wb_inst[6:0])
            7'h37, 7'h17, 7'h6f, 7'h67,
            7'h63, 7'h03, 7'h23, 7'h13,
            7'h33, 7'h0f, 7'h73: op_legal = 1'b1;
            default:             op_legal = 1'b0;
        endcase
    end

    // Branches are made mutually exclusive so the priority order holds.
    always_comb begin
        dec_cause = C_NONE;
        unique case (1'b1)
            !wb.wb_known:
                dec_cause = C_UNKNOWN;
            wb.wb_known && (wb.wb_inst == ECALL_W):
                dec_cause = C_ECALL;
            wb.wb_known && (wb.wb_inst == EBREAK_W):
                dec_cause = C_EBREAK;
            wb.wb_known && !op_legal:
                dec_cause = C_ILLEGAL;
            default: ;
        endcase
    end

    always_comb begin
        halt_hit = 1'b0;
        if (wb.wb_valid) begin
            halt_hit = (dec_cause == C_ECALL)
                    || (dec_cause == C_EBREAK)
                    || ((HALT_ON_ILLEGAL != 0)
                        && ((dec_cause == C_ILLEGAL)
                         || (dec_cause == C_UNKNOWN)));
        end
        legal_ret = wb.wb_valid
                 && (dec_cause != C_ILLEGAL)
                 && (dec_cause != C_UNKNOWN);
        timeout_hit = TO_EN && (cycle_cnt == TO_LAST);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                if (halt_hit) begin
                    state_nx = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end else if (timeout_hit) begin
                    state_nx = S_DONE;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef RISCV_END_MONITOR_SIGNATURE_EN
    // a0 is judged on the cycle that precedes entry into DONE.
    always_comb begin
        pass_nx = pass;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) pass_nx = 1'b0;
            end
            S_RUN: begin
                if (halt_hit && (DRAIN_CYCLES == 0)) begin
                    pass_nx = (dec_cause == C_ECALL)
                           && (wb.wb_a0 == A0_PASS);
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    pass_nx = (halt_cause == C_ECALL)
                           && (wb.wb_a0 == A0_PASS);
                end
            end
            default: ;
        endcase
    end
`else
    logic unused_a0;
    assign unused_a0 = (wb.wb_a0 == A0_PASS);
    assign pass_nx   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            drain_cnt   <= '0;
            halt_cause  <= C_NONE;
            halt_pc     <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            pass        <= 1'b0;
        end else begin
            state <= state_nx;
            pass  <= pass_nx;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        drain_cnt   <= '0;
                        halt_cause  <= C_NONE;
                        halt_pc     <= '0;
                        cycle_cnt   <= '0;
                        instret_cnt <= '0;
                    end
                end
                S_RUN: begin
                    cycle_cnt <= sat_inc(cycle_cnt);
                    if (legal_ret) instret_cnt <= sat_inc(instret_cnt);
                    if (halt_hit) begin
                        halt_cause <= dec_cause;
                        halt_pc    <= wb.wb_pc;
                        drain_cnt  <= DRAIN_LOAD;
                    end else if (timeout_hit) begin
                        halt_cause <= C_TIMEOUT;
                        halt_pc    <= '0;
                    end
                end
                S_DRAIN: begin
                    cycle_cnt <= sat_inc(cycle_cnt);
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);
endmodule
